// File: rtl/axi4_lite_wr_manager.sv
// rtl/axi4_lite_wr_manager.sv - AXI4-Lite manager write engine (AW, W, B channels)
// One local write command at a time; reports BRESP or a timeout abort back to the controller.
module axi4_lite_wr_manager #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_data,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   output logic                    rsp_valid,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   output logic                    busy,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [2:0]              awprot,
   output logic                    wvalid,
   input  logic                    wready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    bvalid,
   output logic                    bready,
   input  logic [1:0]              bresp
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ABORT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEND   = 2'd1,
      S_WAIT_B = 2'd2
   } state_t;

   state_t              state_q;
   logic                awvalid_q;
   logic                wvalid_q;
   logic                bready_q;
   logic                aw_done_q;
   logic                w_done_q;
   logic                busy_q;
   logic                rsp_valid_q;
   logic [1:0]          rsp_resp_q;
   logic                rsp_timeout_q;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                aw_done_d;
   logic                w_done_d;
   logic [CNT_W-1:0]    cnt_d;
   logic                timeout_hit;

   // The counter was cleared on the accept edge, so the Nth edge afterwards sees N-1.
   assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_ABORT);
   assign aw_done_d   = aw_done_q | (awvalid_q & awready);
   assign w_done_d    = w_done_q  | (wvalid_q & wready);

   assign cmd_ready   = (state_q == S_IDLE) && aresetn;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_resp    = rsp_resp_q;
   assign rsp_timeout = rsp_timeout_q;
   assign busy        = busy_q;
   assign awvalid     = awvalid_q;
   assign awaddr      = awaddr_q;
   assign awprot      = 3'b000;
   assign wvalid      = wvalid_q;
   assign wdata       = wdata_q;
   assign wstrb       = wstrb_q;
   assign bready      = bready_q;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q       <= S_IDLE;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         busy_q        <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_resp_q    <= 2'b00;
         rsp_timeout_q <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         cnt_q         <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  awaddr_q  <= cmd_addr;
                  wdata_q   <= cmd_data;
                  wstrb_q   <= cmd_strb;
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_SEND;
               end
            end
            S_SEND: begin
               cnt_q <= cnt_d;
               if (timeout_hit) begin
                  awvalid_q     <= 1'b0;
                  wvalid_q      <= 1'b0;
                  bready_q      <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_resp_q    <= 2'b10;
                  rsp_timeout_q <= 1'b1;
                  busy_q        <= 1'b0;
                  state_q       <= S_IDLE;
               end else begin
                  if (awvalid_q && awready) awvalid_q <= 1'b0;
                  if (wvalid_q && wready)   wvalid_q  <= 1'b0;
                  aw_done_q <= aw_done_d;
                  w_done_q  <= w_done_d;
                  if (aw_done_d && w_done_d) begin
                     bready_q <= 1'b1;
                     state_q  <= S_WAIT_B;
                  end
               end
            end
            S_WAIT_B: begin
               cnt_q <= cnt_d;
               // A response arriving on the abort edge takes priority over the timeout.
               if (bvalid && bready_q) begin
                  bready_q      <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_resp_q    <= bresp;
                  rsp_timeout_q <= 1'b0;
                  busy_q        <= 1'b0;
                  state_q       <= S_IDLE;
               end else if (timeout_hit) begin
                  awvalid_q     <= 1'b0;
                  wvalid_q      <= 1'b0;
                  bready_q      <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_resp_q    <= 2'b10;
                  rsp_timeout_q <= 1'b1;
                  busy_q        <= 1'b0;
                  state_q       <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_wr_manager.sv
// tb/tb_axi4_lite_wr_manager.sv - directed self-checking bench for axi4_lite_wr_manager
module tb_axi4_lite_wr_manager;

   logic        aclk;
   logic        aresetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_data;
   logic [3:0]  cmd_strb;
   logic        rsp_valid;
   logic [1:0]  rsp_resp;
   logic        rsp_timeout;
   logic        busy;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;

   int n_asserts = 0;
   int n_fail    = 0;

   axi4_lite_wr_manager #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_addr    (cmd_addr),
      .cmd_data    (cmd_data),
      .cmd_strb    (cmd_strb),
      .rsp_valid   (rsp_valid),
      .rsp_resp    (rsp_resp),
      .rsp_timeout (rsp_timeout),
      .busy        (busy),
      .awvalid     (awvalid),
      .awready     (awready),
      .awaddr      (awaddr),
      .awprot      (awprot),
      .wvalid      (wvalid),
      .wready      (wready),
      .wdata       (wdata),
      .wstrb       (wstrb),
      .bvalid      (bvalid),
      .bready      (bready),
      .bresp       (bresp)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      aresetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_data  = '0;
      cmd_strb  = '0;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      bresp     = 2'b00;

      // reset state
      tick();
      tick();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_bready", bready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_awaddr", awaddr, 0);
      chk("rst_awprot", awprot, 0);
      aresetn = 1'b1;
      #1;
      chk("rel_cmd_ready", cmd_ready, 1);

      // 1. basic write
      awready = 1'b1; wready = 1'b1;
      cmd_valid = 1'b1; cmd_addr = 32'h04; cmd_data = 32'hCECE_BBBB; cmd_strb = 4'hF;
      tick();                                    // edge N
      cmd_valid = 1'b0;
      chk("t1_awaddr", awaddr, 32'h04);
      chk("t1_wdata", wdata, 32'hCECE_BBBB);
      chk("t1_wstrb", wstrb, 4'hF);
      chk("t1_awvalid", awvalid, 1);
      chk("t1_wvalid", wvalid, 1);
      chk("t1_busy", busy, 1);
      chk("t1_cmd_ready", cmd_ready, 0);
      tick();                                    // N+1 AW/W handshake
      chk("t1_awvalid_drop", awvalid, 0);
      chk("t1_wvalid_drop", wvalid, 0);
      chk("t1_bready", bready, 1);
      chk("t1_no_rsp_yet", rsp_valid, 0);
      bvalid = 1'b1; bresp = 2'b00;
      tick();                                    // N+2 B handshake
      bvalid = 1'b0;
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_resp", rsp_resp, 2'b00);
      chk("t1_rsp_timeout", rsp_timeout, 0);
      chk("t1_busy_clr", busy, 0);
      chk("t1_bready_clr", bready, 0);
      chk("t1_cmd_ready", cmd_ready, 1);
      tick();
      chk("t1_rsp_pulse", rsp_valid, 0);

      // 2. skewed handshakes, early bvalid ignored in SEND
      awready = 1'b0; wready = 1'b1;
      cmd_valid = 1'b1; cmd_addr = 32'h0000_0010; cmd_data = 32'h1234_5678; cmd_strb = 4'h3;
      tick();                                    // N
      cmd_valid = 1'b0;
      tick();                                    // N+1 W handshake
      bvalid = 1'b1; bresp = 2'b00;
      chk("t2_wvalid_low", wvalid, 0);
      chk("t2_awvalid_n1", awvalid, 1);
      tick();                                    // N+2
      chk("t2_awaddr_n2", awaddr, 32'h10);
      chk("t2_bready_n2", bready, 0);
      tick();                                    // N+3
      chk("t2_awvalid_n3", awvalid, 1);
      chk("t2_rsp_n3", rsp_valid, 0);
      awready = 1'b1;
      tick();                                    // N+4 AW handshake
      chk("t2_awvalid_n4", awvalid, 0);
      chk("t2_bready_n4", bready, 1);
      chk("t2_rsp_n4", rsp_valid, 0);
      tick();                                    // N+5 B handshake
      bvalid = 1'b0;
      chk("t2_rsp_valid", rsp_valid, 1);
      chk("t2_wstrb", wstrb, 4'h3);
      tick();

      // 3. error response
      cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_data = 32'hA5A5_0000; cmd_strb = 4'hC;
      tick();
      cmd_valid = 1'b0;
      tick();
      bvalid = 1'b1; bresp = 2'b10;
      tick();
      bvalid = 1'b0; bresp = 2'b00;
      chk("t3_rsp_valid", rsp_valid, 1);
      chk("t3_rsp_resp", rsp_resp, 2'b10);
      chk("t3_rsp_timeout", rsp_timeout, 0);
      chk("t3_cmd_ready", cmd_ready, 1);
      tick();

      // 4. timeout with both readies held low
      awready = 1'b0; wready = 1'b0;
      cmd_valid = 1'b1; cmd_addr = 32'h30; cmd_data = 32'h0; cmd_strb = 4'h1;
      tick();                                    // N
      cmd_valid = 1'b0;
      for (int i = 1; i <= 15; i++) tick();      // N+15
      chk("t4_awvalid_n15", awvalid, 1);
      chk("t4_wvalid_n15", wvalid, 1);
      chk("t4_rsp_n15", rsp_valid, 0);
      tick();                                    // N+16 abort
      chk("t4_awvalid", awvalid, 0);
      chk("t4_wvalid", wvalid, 0);
      chk("t4_rsp_valid", rsp_valid, 1);
      chk("t4_rsp_resp", rsp_resp, 2'b10);
      chk("t4_rsp_timeout", rsp_timeout, 1);
      chk("t4_busy", busy, 0);
      chk("t4_cmd_ready", cmd_ready, 1);
      tick();
      chk("t4_rsp_pulse", rsp_valid, 0);

      // 5. reset during WAIT_B
      awready = 1'b1; wready = 1'b1;
      cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_data = 32'hFFFF_FFFF; cmd_strb = 4'hF;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("t5_in_wait_b", bready, 1);
      aresetn = 1'b0;
      tick();
      chk("t5_awaddr", awaddr, 0);
      chk("t5_wdata", wdata, 0);
      chk("t5_wstrb", wstrb, 0);
      chk("t5_bready", bready, 0);
      chk("t5_busy", busy, 0);
      chk("t5_rsp_valid", rsp_valid, 0);
      chk("t5_cmd_ready_rst", cmd_ready, 0);
      aresetn = 1'b1; bvalid = 1'b1;
      #1;
      chk("t5_cmd_ready", cmd_ready, 1);
      tick();
      bvalid = 1'b0;
      chk("t5_no_rsp", rsp_valid, 0);
      chk("t5_idle_busy", busy, 0);

      // 6. back-to-back commands held on cmd_valid
      bvalid = 1'b1; bresp = 2'b00;
      cmd_valid = 1'b1; cmd_addr = 32'h08; cmd_data = 32'h8888_0008; cmd_strb = 4'hF;
      tick();                                    // N accept first
      chk("t6_awaddr_first", awaddr, 32'h08);
      cmd_addr = 32'h0C; cmd_data = 32'hCCCC_000C;
      tick();                                    // N+1
      chk("t6_first_no_early_b", rsp_valid, 0);
      tick();                                    // N+2 B handshake
      chk("t6_rsp_first", rsp_valid, 1);
      chk("t6_ready_in_rsp", cmd_ready, 1);
      chk("t6_awaddr_hold", awaddr, 32'h08);
      tick();                                    // N+3 accept second
      cmd_valid = 1'b0;
      chk("t6_awaddr_second", awaddr, 32'h0C);
      chk("t6_wdata_second", wdata, 32'hCCCC_000C);
      chk("t6_awvalid_second", awvalid, 1);
      chk("t6_rsp_clear", rsp_valid, 0);
      tick();
      tick();
      bvalid = 1'b0;
      chk("t6_rsp_second", rsp_valid, 1);
      chk("t6_resp_second", rsp_resp, 2'b00);
      tick();
      chk("t6_idle", cmd_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
